// File: rtl/lif_pkg.sv
// Shared types and default widths for the LIF spike-rate readout path.
// Holds the window FSM state encoding and the window result bundle.
package lif_pkg;

    localparam int LIF_CNT_W = 8;
    localparam int LIF_WIN_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lif_state_e;

    typedef struct packed {
        logic [LIF_CNT_W-1:0] count;
        logic                 sat;
        logic [LIF_WIN_W-1:0] isi;
    } lif_res_t;

endpackage

// File: rtl/lif_spike_rate_decoder_if.sv
// Valid/ready result port of the spike-rate decoder.
// master drives res_valid/res_count/res_sat/res_isi; slave drives res_ready.
interface lif_spike_rate_decoder_if
    import lif_pkg::*;
#(
    parameter int CNT_W = LIF_CNT_W,
    parameter int WIN_W = LIF_WIN_W
) ();

    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;
    logic             res_sat;
    logic [WIN_W-1:0] res_isi;

    modport master (
        output res_valid,
        output res_count,
        output res_sat,
        output res_isi,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_count,
        input  res_sat,
        input  res_isi,
        output res_ready
    );

endinterface

// File: rtl/lif_sat_counter.sv
// Saturating up-counter: clr has priority, inc is ignored at all-ones.
// Ports: clk, clr, inc in; q count, at_max high when q is all-ones.
module lif_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = &q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/lif_spike_rate_decoder.sv
// Counts neuron spikes over back-to-back windows and measures the last ISI.
// Ports: clk, rst_n (sync, low), enable, spike_in, window_len in;
// res (master: valid/ready result), overrun pulse, busy (window running).
module lif_spike_rate_decoder
    import lif_pkg::*;
#(
    parameter int CNT_W = LIF_CNT_W,
    parameter int WIN_W = LIF_WIN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     spike_in,
    input  logic [WIN_W-1:0]         window_len,
    lif_spike_rate_decoder_if.master res,
    output logic                     overrun,
    output logic                     busy
);

    lif_state_e       state_q;
    lif_state_e       state_d;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [WIN_W-1:0] isi_q;
    logic             seen_q;
    logic             sat_q;

    logic [CNT_W-1:0] acc;
    logic             acc_max;
    logic [WIN_W-1:0] isi_tmr;
    logic             tmr_max;

    logic             start;
    logic             run;
    logic             wend;
    logic             load;
    logic             drop;
    logic             clr_win;

    logic [CNT_W-1:0] cnt_fin;
    logic             sat_fin;
    logic [WIN_W-1:0] isi_step;
    logic [WIN_W-1:0] isi_fin;

    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             rsat_q;
    logic [WIN_W-1:0] risi_q;
    logic             overrun_q;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        run     = 1'b0;
        wend    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    run  = 1'b1;
                    wend = (win_cnt_q == win_len_q - WIN_W'(1));
                end
            end
        endcase
    end

    // A pending result can be replaced in the same cycle it is accepted.
    assign load    = wend && (!valid_q || res.res_ready);
    assign drop    = wend && !load;
    assign clr_win = !rst_n || start || wend;

    lif_sat_counter #(.W(CNT_W)) u_acc (
        .clk    (clk),
        .clr    (clr_win),
        .inc    (run && spike_in),
        .q      (acc),
        .at_max (acc_max)
    );

    // A spike restarts the interval timer.
    lif_sat_counter #(.W(WIN_W)) u_isi_tmr (
        .clk    (clk),
        .clr    (clr_win || (run && spike_in)),
        .inc    (run),
        .q      (isi_tmr),
        .at_max (tmr_max)
    );

    // Window-end result folds in the spike of the final cycle.
    assign cnt_fin  = acc + CNT_W'(spike_in && !acc_max);
    assign sat_fin  = sat_q || (spike_in && acc_max);
    assign isi_step = tmr_max ? '1 : isi_tmr + WIN_W'(1);
    assign isi_fin  = (spike_in && seen_q) ? isi_step : isi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_len_q <= '0;
            win_cnt_q <= '0;
            isi_q     <= '0;
            seen_q    <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start || wend) begin
                win_len_q <= (window_len == '0) ? WIN_W'(1) : window_len;
                win_cnt_q <= '0;
                isi_q     <= '0;
                seen_q    <= 1'b0;
                sat_q     <= 1'b0;
            end else if (run) begin
                win_cnt_q <= win_cnt_q + WIN_W'(1);
                if (spike_in) begin
                    seen_q <= 1'b1;
                    if (seen_q) begin
                        isi_q <= isi_step;
                    end
                    if (acc_max) begin
                        sat_q <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            count_q   <= '0;
            rsat_q    <= 1'b0;
            risi_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= drop;
            if (load) begin
                valid_q <= 1'b1;
                count_q <= cnt_fin;
                rsat_q  <= sat_fin;
                risi_q  <= isi_fin;
            end else if (valid_q && res.res_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign res.res_valid = valid_q;
    assign res.res_count = count_q;
    assign res.res_sat   = rsat_q;
    assign res.res_isi   = risi_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// Directed bench for lif_spike_rate_decoder: an 8-bit and a 2-bit count
// instance share stimulus; results are compared to hand-derived values.
module tb_lif_spike_rate_decoder;
    import lif_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        spike_in;
    logic        ready;
    logic [15:0] window_len;
    logic        a_ovr;
    logic        a_busy;
    logic        b_ovr;
    logic        b_busy;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lif_spike_rate_decoder_if #(.CNT_W(8), .WIN_W(16)) a_if ();
    lif_spike_rate_decoder_if #(.CNT_W(2), .WIN_W(16)) b_if ();

    assign a_if.res_ready = ready;
    assign b_if.res_ready = ready;

    lif_spike_rate_decoder #(.CNT_W(8), .WIN_W(16)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .res        (a_if.master),
        .overrun    (a_ovr),
        .busy       (a_busy)
    );

    lif_spike_rate_decoder #(.CNT_W(2), .WIN_W(16)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .res        (b_if.master),
        .overrun    (b_ovr),
        .busy       (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int c, input bit s,
                           input int i);
        lif_res_t g;
        lif_res_t e;
        g.count = a_if.res_count;
        g.sat   = a_if.res_sat;
        g.isi   = a_if.res_isi;
        e.count = 8'(c);
        e.sat   = s;
        e.isi   = 16'(i);
        chk(tag, {7'b0, g}, {7'b0, e});
    endtask

    task automatic cyc(input logic sp);
        spike_in = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        ready      = 1'b1;
        window_len = 16'd0;
        cyc(1'b0);
        cyc(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        // basic window, len 10, spikes at 2,5,9
        do_reset();
        rst_n = 1'b0;
        cyc(1'b0);
        chk("rst valid", {31'b0, a_if.res_valid}, 0);
        chk_res("rst res", 0, 0, 0);
        chk("rst ovr", {31'b0, a_ovr}, 0);
        chk("rst busy", {31'b0, a_busy}, 0);
        chk("rst b", {28'b0, b_if.res_valid, b_ovr, b_busy, b_if.res_sat}, 0);
        rst_n      = 1'b1;
        enable     = 1'b1;
        window_len = 16'd10;
        cyc(1'b0);
        chk("t1 busy", {31'b0, a_busy}, 1);
        for (int c = 0; c < 10; c++) begin
            cyc(c == 2 || c == 5 || c == 9);
            if (c == 8) chk("t1 early", {31'b0, a_if.res_valid}, 0);
        end
        chk("t1 valid", {31'b0, a_if.res_valid}, 1);
        chk_res("t1 res", 3, 0, 4);
        chk("t1 b cnt", {29'b0, b_if.res_count, b_if.res_sat}, {29'b0, 2'd3, 1'b0});
        chk("t1 b isi", {16'b0, b_if.res_isi}, 4);
        for (int c = 0; c < 10; c++) begin
            cyc(c == 0);
            if (c == 0) chk("t1 clr", {31'b0, a_if.res_valid}, 0);
        end
        chk("t1 w2 valid", {31'b0, a_if.res_valid}, 1);
        chk_res("t1 w2 res", 1, 0, 0);

        // len 4, spike held high, 2-bit counter saturates
        do_reset();
        enable     = 1'b1;
        window_len = 16'd4;
        cyc(1'b1);
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(1'b1);
                if (c == 2) chk("t2 gap", {31'b0, a_if.res_valid}, 0);
            end
            chk("t2 valid", {31'b0, b_if.res_valid}, 1);
            chk("t2 b sat", {29'b0, b_if.res_count, b_if.res_sat}, {29'b0, 2'd3, 1'b1});
            chk_res("t2 a res", 4, 0, 1);
        end

        // stalled consumer, overrun, then coincident accept/load
        do_reset();
        ready      = 1'b0;
        enable     = 1'b1;
        window_len = 16'd5;
        cyc(1'b0);
        for (int c = 0; c < 5; c++) cyc(c == 1 || c == 3);
        chk("t3 valid", {31'b0, a_if.res_valid}, 1);
        chk_res("t3 w1", 2, 0, 2);
        for (int c = 0; c < 5; c++) begin
            cyc(c <= 2);
            if (c == 2) chk_res("t3 hold", 2, 0, 2);
            if (c == 3) chk("t3 no ovr", {31'b0, a_ovr}, 0);
        end
        chk("t3 ovr", {31'b0, a_ovr}, 1);
        chk_res("t3 kept", 2, 0, 2);
        cyc(1'b0);
        chk("t3 ovr pulse", {31'b0, a_ovr}, 0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        ready = 1'b1;
        chk_res("t3 accept", 2, 0, 2);
        cyc(1'b0);
        chk("t4 valid", {31'b0, a_if.res_valid}, 1);
        chk_res("t4 res", 1, 0, 0);
        chk("t4 ovr", {31'b0, a_ovr}, 0);
        cyc(1'b0);
        chk("t4 drain", {31'b0, a_if.res_valid}, 0);

        // enable dropped mid-window, then len 0 behaves as len 1
        do_reset();
        enable     = 1'b1;
        window_len = 16'd8;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        enable = 1'b0;
        cyc(1'b0);
        chk("t5 busy", {31'b0, a_busy}, 0);
        cyc(1'b0);
        cyc(1'b0);
        chk("t5 idle", {30'b0, a_if.res_valid, a_ovr}, 0);
        window_len = 16'd0;
        enable     = 1'b1;
        cyc(1'b0);
        chk("t5 run", {30'b0, a_busy, a_if.res_valid}, 2);
        cyc(1'b1);
        chk("t5 v1", {31'b0, a_if.res_valid}, 1);
        chk_res("t5 r1", 1, 0, 0);
        cyc(1'b0);
        chk_res("t5 r2", 0, 0, 0);
        cyc(1'b1);
        chk_res("t5 r3", 1, 0, 0);
        chk("t5 v3", {30'b0, a_if.res_valid, a_ovr}, 2);

        // reset mid-window with a result pending
        do_reset();
        ready      = 1'b0;
        enable     = 1'b1;
        window_len = 16'd3;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        chk("t6 pend", {31'b0, a_if.res_valid}, 1);
        chk_res("t6 pres", 1, 0, 0);
        cyc(1'b1);
        rst_n = 1'b0;
        cyc(1'b0);
        chk("t6 rst", {29'b0, a_if.res_valid, a_ovr, a_busy}, 0);
        chk_res("t6 rres", 0, 0, 0);
        rst_n  = 1'b1;
        enable = 1'b0;
        cyc(1'b0);
        chk("t6 idle", {30'b0, a_busy, a_if.res_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
